// File: rtl/fb_swap_scheduler.sv
// Double-buffer controller: clears the back buffer, hands the write port to the renderer,
// and swaps front/back on new_frame once the frame is done. Optional: FRAME_DROP_CNT_EN.
module fb_swap_scheduler #(
  parameter int         FB_WIDTH    = 320,
  parameter int         FB_HEIGHT   = 240,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        new_frame,
  output logic        draw_start,
  input  logic        draw_done,
  input  logic        wr_req,
  input  logic [8:0]  wr_x,
  input  logic [7:0]  wr_y,
  input  logic [2:0]  wr_data,
  output logic        wr_ack,
  output logic        fb_we,
  output logic [8:0]  fb_x,
  output logic [7:0]  fb_y,
  output logic [2:0]  fb_data,
  output logic        fb_buf,
  output logic        front_buf,
`ifdef FRAME_DROP_CNT_EN
  output logic [15:0] drop_count,
`endif
  output logic        busy_clear
);

  typedef enum logic [1:0] {S_CLEAR, S_START, S_DRAW, S_WAIT_SWAP} state_t;

  localparam logic [8:0] X_LAST = 9'(FB_WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(FB_HEIGHT - 1);

  state_t     r_state, w_next;
  logic       w_swap, w_ack, w_clear_last, w_in_range;
  logic [8:0] r_cx;
  logic [7:0] r_cy;
  logic       r_front, r_draw_start, r_fb_we;
  logic [8:0] r_fb_x;
  logic [7:0] r_fb_y;
  logic [2:0] r_fb_data;

  assign w_clear_last = (r_cx == X_LAST) && (r_cy == Y_LAST);
  assign w_in_range   = ({1'b0, wr_x} < 10'(FB_WIDTH)) && ({1'b0, wr_y} < 9'(FB_HEIGHT));

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_CLEAR;
    else       r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    w_swap = 1'b0;
    w_ack  = 1'b0;
    case (r_state)
      S_CLEAR: if (w_clear_last) w_next = S_START;
      S_START: w_next = S_DRAW;
      S_DRAW: begin
        w_ack = wr_req;
        if (draw_done) begin
          if (new_frame) begin
            w_swap = 1'b1;
            w_next = S_CLEAR;
          end else begin
            w_next = S_WAIT_SWAP;
          end
        end
      end
      S_WAIT_SWAP: begin
        if (new_frame) begin
          w_swap = 1'b1;
          w_next = S_CLEAR;
        end
      end
      default: w_next = S_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_front      <= 1'b0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_draw_start <= 1'b0;
      r_fb_we      <= 1'b0;
      r_fb_x       <= '0;
      r_fb_y       <= '0;
      r_fb_data    <= '0;
    end else begin
      r_draw_start <= (r_state == S_START);
      r_fb_we      <= 1'b0;
      if (w_swap) begin
        r_front <= ~r_front;
        r_cx    <= '0;
        r_cy    <= '0;
      end
      case (r_state)
        S_CLEAR: begin
          r_fb_we   <= 1'b1;
          r_fb_x    <= r_cx;
          r_fb_y    <= r_cy;
          r_fb_data <= CLEAR_COLOR;
          if (r_cx == X_LAST) begin
            r_cx <= '0;
            r_cy <= (r_cy == Y_LAST) ? 8'd0 : r_cy + 8'd1;
          end else begin
            r_cx <= r_cx + 9'd1;
          end
        end
        S_DRAW: begin
          // Out-of-range writes are acknowledged but dropped here.
          if (w_ack && w_in_range) begin
            r_fb_we   <= 1'b1;
            r_fb_x    <= wr_x;
            r_fb_y    <= wr_y;
            r_fb_data <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FRAME_DROP_CNT_EN
  logic [15:0] r_drop;
  always_ff @(posedge Clk) begin
    if (Reset)                                           r_drop <= '0;
    else if (new_frame && !w_swap && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
  end
  assign drop_count = r_drop;
`endif

  assign draw_start = r_draw_start;
  assign wr_ack     = w_ack;
  assign fb_we      = r_fb_we;
  assign fb_x       = r_fb_x;
  assign fb_y       = r_fb_y;
  assign fb_data    = r_fb_data;
  assign front_buf  = r_front;
  assign fb_buf     = ~r_front;
  assign busy_clear = (r_state == S_CLEAR);

endmodule

// File: tb/tb_fb_swap_scheduler.sv
// Scoreboard bench for fb_swap_scheduler on a reduced-height frame (320x24) to keep clears short.
module tb_fb_swap_scheduler;
  localparam int W = 320;
  localparam int H = 24;

  logic        Clk = 1'b0;
  logic        Reset, new_frame, draw_done, wr_req;
  logic [8:0]  wr_x;
  logic [7:0]  wr_y;
  logic [2:0]  wr_data;
  logic        draw_start, wr_ack, fb_we, fb_buf, front_buf, busy_clear;
  logic [8:0]  fb_x;
  logic [7:0]  fb_y;
  logic [2:0]  fb_data;
`ifdef FRAME_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  fb_swap_scheduler #(.FB_WIDTH(W), .FB_HEIGHT(H), .CLEAR_COLOR(3'b000)) dut (
    .Clk(Clk), .Reset(Reset), .new_frame(new_frame), .draw_start(draw_start),
    .draw_done(draw_done), .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ack(wr_ack), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data),
    .fb_buf(fb_buf), .front_buf(front_buf),
`ifdef FRAME_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .busy_clear(busy_clear)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int n_pop  = 0;
  int ds_count = 0;
  logic [20:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Each observed framebuffer write must match the oldest expected write.
  always @(negedge Clk) begin
    if (draw_start) ds_count++;
    if (fb_we) begin
      if (sb.size() == 0) begin
        check("unexpected_we", 32'(fb_we), 32'd0);
      end else begin
        check("fb_write", 32'({fb_buf, fb_x, fb_y, fb_data}), 32'(sb.pop_front()));
        n_pop++;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_clear(input logic b);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        sb.push_back({b, 9'(x), 8'(y), 3'b000});
  endtask

  // Returns right after the posedge at which the queue is found empty.
  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge Clk);
      if (sb.size() == 0) break;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // Waits out a clear and checks the single draw_start pulse that follows it.
  task automatic finish_clear(input string tag);
    int base;
    base = ds_count;
    drain(W * H + 10);
    #1;
    check({tag, "_draw_start"}, 32'(draw_start), 32'd1);
    check({tag, "_busy_after"}, 32'(busy_clear), 32'd0);
    step();
    check({tag, "_ds_once"}, 32'(ds_count - base), 32'd1);
    check({tag, "_ds_low"}, 32'(draw_start), 32'd0);
  endtask

  initial begin
    int base;
    logic [8:0] rx;
    logic [7:0] ry;
    logic [2:0] rd;

    Reset = 1'b1; new_frame = 1'b0; draw_done = 1'b0;
    wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    repeat (3) step();
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_xyd", 32'({fb_x, fb_y, fb_data}), 32'd0);
    check("rst_front", 32'(front_buf), 32'd0);
    check("rst_fb_buf", 32'(fb_buf), 32'd1);
    check("rst_draw_start", 32'(draw_start), 32'd0);
`ifdef FRAME_DROP_CNT_EN
    check("rst_drop", 32'(drop_count), 32'd0);
`endif

    push_clear(1'b1);
    Reset = 1'b0;
    step();
    wr_req = 1'b1; wr_x = 9'd10; wr_y = 8'd2;
    #1;
    check("clear_busy", 32'(busy_clear), 32'd1);
    check("clear_no_ack", 32'(wr_ack), 32'd0);
    wr_req = 1'b0;
    finish_clear("clr1");

    // DRAW: accepted write, then out-of-range coordinates, then the last valid pixel.
    wr_req = 1'b1; wr_x = 9'd10; wr_y = 8'd20; wr_data = 3'd5;
    sb.push_back({1'b1, 9'd10, 8'd20, 3'd5});
    #1;
    check("draw_ack", 32'(wr_ack), 32'd1);
    step();
    check("draw_we", 32'({fb_we, fb_x, fb_y, fb_data, fb_buf}), 32'({1'b1, 9'd10, 8'd20, 3'd5, 1'b1}));
    wr_x = 9'd320; wr_y = 8'd5;
    #1;
    check("oor_x_ack", 32'(wr_ack), 32'd1);
    step();
    wr_x = 9'd5; wr_y = 8'd240;
    #1;
    check("oor_x_no_we", 32'(fb_we), 32'd0);
    check("oor_y_ack", 32'(wr_ack), 32'd1);
    step();
    check("oor_y_no_we", 32'(fb_we), 32'd0);
    wr_x = 9'(W - 1); wr_y = 8'(H - 1); wr_data = 3'd7;
    sb.push_back({1'b1, 9'(W - 1), 8'(H - 1), 3'd7});
    for (int i = 0; i < 8; i++) begin
      step();
      rx = 9'($urandom_range(W - 1)); ry = 8'($urandom_range(H - 1)); rd = 3'($urandom_range(7));
      wr_x = rx; wr_y = ry; wr_data = rd;
      sb.push_back({1'b1, rx, ry, rd});
    end
    step();
    wr_req = 1'b0;
    repeat (2) step();
    check("draw_sb_empty", 32'(sb.size()), 32'd0);

    // draw_done, wait 100 cycles in WAIT_SWAP, then swap on new_frame.
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    wr_req = 1'b1; wr_x = 9'd1; wr_y = 8'd1;
    #1;
    check("wait_no_ack", 32'(wr_ack), 32'd0);
    repeat (100) step();
    wr_req = 1'b0;
    check("wait_front", 32'(front_buf), 32'd0);
    push_clear(1'b0);
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    check("swap_front", 32'(front_buf), 32'd1);
    check("swap_fb_buf", 32'(fb_buf), 32'd0);
    check("swap_clear", 32'(busy_clear), 32'd1);

    // new_frame during CLEAR is dropped; the clear carries on.
    repeat (50) step();
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    check("drop_front", 32'(front_buf), 32'd1);
    check("drop_busy", 32'(busy_clear), 32'd1);
`ifdef FRAME_DROP_CNT_EN
    check("drop_count1", 32'(drop_count), 32'd1);
`endif
    finish_clear("clr2");

    // draw_done with new_frame in the same cycle: straight back to CLEAR.
    push_clear(1'b1);
    draw_done = 1'b1; new_frame = 1'b1;
    step();
    draw_done = 1'b0; new_frame = 1'b0;
    check("imm_front", 32'(front_buf), 32'd0);
    check("imm_clear", 32'(busy_clear), 32'd1);
`ifdef FRAME_DROP_CNT_EN
    check("imm_drop", 32'(drop_count), 32'd1);
`endif

    // Reset at clear pixel 5000 restarts the clear from (0,0).
    base = n_pop;
    for (int i = 0; i < 6000; i++) begin
      @(posedge Clk);
      if (n_pop - base >= 5000) break;
    end
    check("reach_5000", 32'(n_pop - base >= 5000), 32'd1);
    #1;
    Reset = 1'b1;
    step();
    check("rst_mid_we", 32'(fb_we), 32'd0);
    check("rst_mid_busy", 32'(busy_clear), 32'd1);
`ifdef FRAME_DROP_CNT_EN
    check("rst_mid_drop", 32'(drop_count), 32'd0);
`endif
    sb.delete();
    push_clear(1'b1);
    Reset = 1'b0;
    finish_clear("clr3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
